// File: rtl/ma_unit.sv
// Memory-access stage: one load or store per request over a req/ack handshake,
// stalling the core until the access completes, is rejected or times out.
module ma_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        isLd,
   input  logic        isSt,
   input  logic [31:0] aluResult,
   input  logic [31:0] op2,
   output logic        stall,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   input  logic [31:0] memRdata,
   input  logic        memAck,
   output logic [31:0] ldResult,
   output logic        done,
   output logic        errValid,
   output logic [1:0]  errCode
);

   // Counter only has to reach TIMEOUT-1.
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   localparam logic [1:0] ErrNone      = 2'b00;
   localparam logic [1:0] ErrMisalign  = 2'b01;
   localparam logic [1:0] ErrTimeout   = 2'b10;
   localparam logic [1:0] ErrBothOps   = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDone,
      StErr
   } stateT;

   stateT           stateQ, stateD;
   logic            memReqQ, memReqD;
   logic            memWeQ, memWeD;
   logic [31:0]     memAddrQ, memAddrD;
   logic [31:0]     memWdataQ, memWdataD;
   logic [31:0]     ldResultQ, ldResultD;
   logic [1:0]      errCodeQ, errCodeD;
   logic [CntW-1:0] cntQ, cntD;

   logic oneOp;
   logic aligned;
   logic accept;

   assign oneOp   = isLd ^ isSt;
   assign aligned = (aluResult[1:0] == 2'b00);
   assign accept  = start & oneOp & aligned;

   always_comb begin
      stateD    = stateQ;
      memReqD   = memReqQ;
      memWeD    = memWeQ;
      memAddrD  = memAddrQ;
      memWdataD = memWdataQ;
      ldResultD = ldResultQ;
      errCodeD  = ErrNone;
      cntD      = cntQ;

      unique case (stateQ)
         StIdle: begin
            if (start) begin
               if (isLd && isSt) begin
                  errCodeD = ErrBothOps;
                  stateD   = StErr;
               end else if (oneOp && !aligned) begin
                  errCodeD = ErrMisalign;
                  stateD   = StErr;
               end else if (oneOp) begin
                  memAddrD  = aluResult;
                  memWdataD = op2;
                  memWeD    = isSt;
                  memReqD   = 1'b1;
                  cntD      = '0;
                  stateD    = StReq;
               end
            end
         end

         StReq: begin
            // Ack has priority over a timeout in the same cycle.
            if (memAck) begin
               memReqD = 1'b0;
               if (!memWeQ) begin
                  ldResultD = memRdata;
               end
               stateD = StDone;
            end else if (cntQ == CntLast) begin
               memReqD  = 1'b0;
               errCodeD = ErrTimeout;
               stateD   = StErr;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end

         StDone: stateD = StIdle;

         StErr: stateD = StIdle;

         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= StIdle;
         memReqQ   <= 1'b0;
         memWeQ    <= 1'b0;
         memAddrQ  <= '0;
         memWdataQ <= '0;
         ldResultQ <= '0;
         errCodeQ  <= ErrNone;
         cntQ      <= '0;
      end else begin
         stateQ    <= stateD;
         memReqQ   <= memReqD;
         memWeQ    <= memWeD;
         memAddrQ  <= memAddrD;
         memWdataQ <= memWdataD;
         ldResultQ <= ldResultD;
         errCodeQ  <= errCodeD;
         cntQ      <= cntD;
      end
   end

   assign stall    = ((stateQ == StIdle) && accept) || (stateQ == StReq);
   assign memReq   = memReqQ;
   assign memWe    = memWeQ;
   assign memAddr  = memAddrQ;
   assign memWdata = memWdataQ;
   assign ldResult = ldResultQ;
   assign done     = (stateQ == StDone);
   assign errValid = (stateQ == StErr);
   assign errCode  = errCodeQ;

endmodule

// File: tb/tb_ma_unit.sv
// Scoreboard bench for ma_unit: driver pushes expected outcomes, a negedge monitor
// pops and compares them on every done/errValid pulse.
module tb_ma_unit;

   localparam int unsigned TO = 4;

   logic        clk;
   logic        reset;
   logic        start;
   logic        isLd;
   logic        isSt;
   logic [31:0] aluResult;
   logic [31:0] op2;
   logic        stall;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [31:0] memRdata;
   logic        memAck;
   logic [31:0] ldResult;
   logic        done;
   logic        errValid;
   logic [1:0]  errCode;

   ma_unit #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .isLd      (isLd),
      .isSt      (isSt),
      .aluResult (aluResult),
      .op2       (op2),
      .stall     (stall),
      .memReq    (memReq),
      .memWe     (memWe),
      .memAddr   (memAddr),
      .memWdata  (memWdata),
      .memRdata  (memRdata),
      .memAck    (memAck),
      .ldResult  (ldResult),
      .done      (done),
      .errValid  (errValid),
      .errCode   (errCode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        isErr;
      logic [1:0]  code;
      logic [31:0] ld;
      int          reqCycles;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } expT;

   expT         q[$];
   int          nChecks = 0;
   int          nPass = 0;
   logic [31:0] modelLd = '0;
   int          reqCnt = 0;

   function automatic void chkW(string name, logic [31:0] act, logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endfunction

   function automatic void chkB(string name, logic act, logic exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %b, want %b", name, act, exp);
   endfunction

   // Monitor: compares every pulse against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset) begin
         reqCnt = 0;
      end else begin
         if (memReq) begin
            reqCnt++;
            if (q.size() == 0) begin
               chkB("memReq_unexpected", memReq, 1'b0);
            end else begin
               chkW("memAddr", memAddr, q[0].addr);
               chkB("memWe", memWe, q[0].we);
               chkW("memWdata", memWdata, q[0].wdata);
            end
         end
         if (done || errValid) begin
            if (q.size() == 0) begin
               chkB("pulse_unexpected", done | errValid, 1'b0);
            end else begin
               expT e;
               e = q.pop_front();
               chkB("errValid", errValid, e.isErr);
               chkB("done", done, !e.isErr);
               chkW("errCode", {30'b0, errCode}, {30'b0, e.code});
               chkW("ldResult", ldResult, e.ld);
               chkW("reqCycles", reqCnt, e.reqCycles);
            end
            reqCnt = 0;
         end else begin
            chkW("errCode_quiet", {30'b0, errCode}, 32'h0);
         end
      end
   end

   // Cycle spent in DONE/ERR: random junk on the inputs must be ignored.
   task automatic junkCycle();
      start     = 1'($urandom_range(0, 1));
      isLd      = 1'($urandom_range(0, 1));
      isSt      = ~isLd;
      aluResult = {$urandom_range(0, 255) , 2'b00};
      memAck    = 1'($urandom_range(0, 1));
      #1 chkB("stall_post", stall, 1'b0);
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      memAck = 1'b0;
   endtask

   task automatic idleCycle(input bit strayAck);
      start     = 1'b0;
      isLd      = 1'($urandom_range(0, 1));
      isSt      = 1'($urandom_range(0, 1));
      aluResult = $urandom;
      memAck    = strayAck;
      memRdata  = $urandom;
      #1 chkB("stall_idle", stall, 1'b0);
      @(posedge clk);
      @(negedge clk);
      memAck = 1'b0;
   endtask

   // One instruction from IDLE; d is the cycle of memReq in which ack arrives (>TO: never).
   task automatic run(input bit ld, input bit st, input logic [31:0] addr,
                      input logic [31:0] data, input int d, input logic [31:0] rdata);
      expT e;
      bit  one;
      bit  algn;
      bit  push;
      one  = ld ^ st;
      algn = (addr[1:0] == 2'b00);
      push = 1'b1;
      e.addr  = addr;
      e.we    = st;
      e.wdata = data;
      if (!ld && !st) begin
         push = 1'b0;
      end else if (ld && st) begin
         e.isErr = 1'b1; e.code = 2'b11; e.reqCycles = 0;
      end else if (!algn) begin
         e.isErr = 1'b1; e.code = 2'b01; e.reqCycles = 0;
      end else if (d <= int'(TO)) begin
         if (ld) modelLd = rdata;
         e.isErr = 1'b0; e.code = 2'b00; e.reqCycles = d;
      end else begin
         e.isErr = 1'b1; e.code = 2'b10; e.reqCycles = int'(TO);
      end
      e.ld = modelLd;
      if (push) q.push_back(e);

      start = 1'b1; isLd = ld; isSt = st; aluResult = addr; op2 = data;
      #1 chkB("stall_start", stall, one & algn);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      isLd = 1'($urandom_range(0, 1));
      isSt = 1'($urandom_range(0, 1));
      aluResult = $urandom;
      op2 = $urandom;
      if (!push) return;
      if (one && algn) begin
         for (int c = 1; c <= int'(TO); c++) begin
            memAck   = (c == d);
            memRdata = (c == d) ? rdata : $urandom;
            #1 chkB("stall_req", stall, 1'b1);
            @(posedge clk);
            @(negedge clk);
            if (c == d) break;
         end
         memAck = 1'b0;
      end
      junkCycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] saved;
      reset = 1'b1; start = 1'b0; isLd = 1'b0; isSt = 1'b0;
      aluResult = '0; op2 = '0; memRdata = '0; memAck = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chkB("rst_memReq", memReq, 1'b0);
      chkB("rst_memWe", memWe, 1'b0);
      chkB("rst_done", done, 1'b0);
      chkB("rst_errValid", errValid, 1'b0);
      chkW("rst_errCode", {30'b0, errCode}, 32'h0);
      chkW("rst_memAddr", memAddr, 32'h0);
      chkW("rst_memWdata", memWdata, 32'h0);
      chkW("rst_ldResult", ldResult, 32'h0);
      chkB("rst_stall", stall, 1'b0);
      reset = 1'b0;

      run(1'b1, 1'b0, 32'h100, 32'h5555AAAA, 3, 32'hDEADBEEF);
      chkW("load_result", ldResult, 32'hDEADBEEF);
      run(1'b0, 1'b1, 32'h40, 32'h12345678, 1, 32'hCAFEF00D);
      chkW("store_keeps_ld", ldResult, 32'hDEADBEEF);
      run(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h11111111);
      run(1'b1, 1'b0, 32'h80, 32'h0, TO + 1, 32'h22222222);
      idleCycle(1'b1);
      run(1'b1, 1'b1, 32'h44, 32'h0, 1, 32'h33333333);
      run(1'b0, 1'b0, 32'h48, 32'h0, 1, 32'h44444444);
      idleCycle(1'b0);

      // Reset in the middle of a request.
      begin
         expT e;
         e.isErr = 1'b0; e.code = 2'b00; e.ld = 32'h0; e.reqCycles = 0;
         e.addr = 32'h200; e.we = 1'b0; e.wdata = 32'h0;
         q.push_back(e);
         start = 1'b1; isLd = 1'b1; isSt = 1'b0; aluResult = 32'h200; op2 = 32'h0;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         reset = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chkB("rstreq_memReq", memReq, 1'b0);
         chkB("rstreq_done", done, 1'b0);
         chkW("rstreq_ldResult", ldResult, 32'h0);
         q.delete();
         modelLd = '0;
         reset = 1'b0;
         idleCycle(1'b1);
         idleCycle(1'b0);
         run(1'b1, 1'b0, 32'h300, 32'h0, 2, 32'hA5A5_5A5A);
      end

      for (int i = 0; i < 300; i++) begin
         int          kind;
         bit          ld;
         bit          st;
         logic [31:0] addr;
         kind = $urandom_range(0, 9);
         ld   = 1'($urandom_range(0, 1));
         st   = ~ld;
         if (kind == 0) begin ld = 1'b1; st = 1'b1; end
         else if (kind == 1) begin ld = 1'b0; st = 1'b0; end
         addr = $urandom;
         if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
         run(ld, st, addr, $urandom, $urandom_range(1, TO + 1), $urandom);
         if ($urandom_range(0, 3) == 0) idleCycle(1'($urandom_range(0, 1)));
      end

      repeat (3) idleCycle(1'b0);
      saved = modelLd;
      chkW("final_ldResult", ldResult, saved);
      chkW("queue_drained", q.size(), 32'h0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
